// File: rtl/div_sequencer.sv
// div_sequencer
//   Sequences the external 32-bit radix-4 iterative divider for the EX stage
//   (DIV/DIVU). Signed operands are converted to magnitudes before the divider
//   and the results are sign-corrected afterwards. Divide-by-zero bypasses the
//   divider. A flush mid-division drains the divider and drops its result.
//   A watchdog aborts WAIT/DRAIN if the divider never signals completion.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   req_valid/req_signed       divide request (level) and DIV(1)/DIVU(0)
//   req_op_a/req_op_b          dividend / divisor
//   flush                      cancel the in-flight operation
//   stall                      hold EX stage (combinational)
//   resp_valid                 one-cycle result pulse
//   resp_quotient/remainder    results, held until the next completion
//   resp_div0                  divisor was zero (qualified by resp_valid)
//   timeout_err                sticky watchdog flag
//   div_en                     one-cycle start pulse to the divider
//   div_dividend/div_divisor   operand magnitudes to the divider
//   div_quotient/remainder     divider results, valid with div_done
//   div_done                   divider completion pulse
module div_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_op_a,
    input  logic [31:0] req_op_b,
    input  logic        flush,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_quotient,
    output logic [31:0] resp_remainder,
    output logic        resp_div0,
    output logic        timeout_err,
    output logic        div_en,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic        div_done
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t        state;
    logic          neg_q;
    logic          neg_r;
    logic [CW-1:0] tmo_cnt;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Magnitude as 0-x modulo 2^32, so 0x80000000 maps to itself.
    always_comb begin
        a_mag = (req_signed && req_op_a[31]) ? (32'd0 - req_op_a) : req_op_a;
        b_mag = (req_signed && req_op_b[31]) ? (32'd0 - req_op_b) : req_op_b;
        q_fix = neg_q ? (32'd0 - div_quotient)  : div_quotient;
        r_fix = neg_r ? (32'd0 - div_remainder) : div_remainder;
    end

    assign stall = req_valid & ~resp_valid & ~flush;

    // resp_valid is raised on the edge leaving DONE, so it is high during the
    // first IDLE cycle; IDLE ignores req_valid in that cycle because EX still
    // presents the request that just completed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            tmo_cnt        <= '0;
            resp_valid     <= 1'b0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_div0      <= 1'b0;
            timeout_err    <= 1'b0;
            div_en         <= 1'b0;
            div_dividend   <= '0;
            div_divisor    <= '0;
        end else begin
            div_en     <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && !flush && !resp_valid) begin
                        if (req_op_b == '0) begin
                            resp_quotient  <= '1;
                            resp_remainder <= req_op_a;
                            resp_div0      <= 1'b1;
                            state          <= S_DONE;
                        end else begin
                            div_dividend <= a_mag;
                            div_divisor  <= b_mag;
                            neg_q        <= req_signed & (req_op_a[31] ^ req_op_b[31]);
                            neg_r        <= req_signed & req_op_a[31];
                            div_en       <= 1'b1;
                            state        <= S_START;
                        end
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (div_done) begin
                        // Completion coinciding with a flush: divider is
                        // already idle, so nothing is left to drain.
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            resp_quotient  <= q_fix;
                            resp_remainder <= r_fix;
                            resp_div0      <= 1'b0;
                            state          <= S_DONE;
                        end
                    end else if (flush) begin
                        tmo_cnt <= '0;
                        state   <= S_DRAIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err    <= 1'b1;
                        resp_quotient  <= '0;
                        resp_remainder <= '0;
                        resp_div0      <= 1'b0;
                        state          <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    resp_valid <= 1'b1;
                    state      <= S_IDLE;
                end
                S_DRAIN: begin
                    if (div_done) begin
                        state <= S_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
